t05_bit_packer: RTL and testbench

Serial-to-word packer directly downstream of header synthesis and the code-bit emitter in the team_05 Huffman compressor. Accepts one bit per cycle on a valid strobe, packs bits MSB-first into 32-bit words, and buffers them in a small FIFO. Drains the FIFO to SRAM through a req/ack write port with an auto-incrementing address. On a flush strobe it emits the zero-padded partial word, then reports completion once every word has been acknowledged.

---
 rtl/t05_pkg.sv | 16 +
 rtl/t05_word_fifo.sv | 69 ++++++
 rtl/t05_bit_packer.sv | 142 ++++++++++++++
 tb/tb_t05_bit_packer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_pkg.sv
// t05_pkg: definitions shared by the team_05 bit packer and its word FIFO.
//   ctrl_state_t : packer controller states (RUN, PAD, DRAIN)
//   WORD_W       : packed word width in bits
//   ADDR_STEP    : byte-address increment between consecutive words
package t05_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    localparam int          WORD_W    = 32;
    localparam logic [31:0] ADDR_STEP = 32'd4;

endpackage

// File: rtl/t05_word_fifo.sv
// t05_word_fifo: synchronous show-ahead FIFO holding packed words.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous flush of all entries
//   push/din : write din when push is high (dropped when full unless popping)
//   pop      : remove head entry (ignored when empty)
//   head     : current head entry, valid whenever empty is low
//   full, empty, count : occupancy status
module t05_word_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every always_ff reads the pre-edge value of every register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only observable once
    // the pointers say they were written, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/t05_bit_packer.sv
// t05_bit_packer: packs a serial bit stream MSB-first into 32-bit words,
// buffers them in a word FIFO and drains them to SRAM over a req/ack port.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin a new stream (clears counters, FIFO, address)
//   bit_valid/bit_in: one serial bit per cycle, never stalled
//   flush           : end of stream; pad and emit the partial word
//   mem_ack         : SRAM accepted the presented write
//   mem_req/addr/wdata/sel : SRAM write port
//   bits_written    : bits accepted since start
//   overflow        : sticky, a word was dropped on a full FIFO
//   busy            : not idle (controller, FIFO or partial word pending)
//   flush_done      : one-cycle pulse once a flush has fully drained
module t05_bit_packer
    import t05_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        bit_valid,
    input  logic        bit_in,
    input  logic        flush,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sel,
    output logic [31:0] bits_written,
    output logic        overflow,
    output logic        busy,
    output logic        flush_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ctrl_state_t       state;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_next;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] push_data;
    logic [WORD_W-1:0] fifo_head;
    logic [4:0]        bit_cnt;
    logic [4:0]        bit_cnt_next;
    logic              pad_push;
    logic              word_push;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        merged          = shreg;
        merged[~bit_cnt] = bit_in;          // ~bit_cnt == 31 - bit_cnt
        shreg_next      = shreg;
        bit_cnt_next    = bit_cnt;
        pad_push        = (state == PAD) && (bit_cnt != 5'd0);
        word_push       = bit_valid && (bit_cnt == 5'd31) && !pad_push;
        push_data       = pad_push ? shreg : merged;

        if (pad_push) begin
            // The padded word leaves now; a stray bit starts the next word.
            shreg_next             = '0;
            shreg_next[WORD_W-1]   = bit_valid & bit_in;
            bit_cnt_next           = {4'd0, bit_valid};
        end else if (bit_valid) begin
            shreg_next   = word_push ? '0 : merged;
            bit_cnt_next = bit_cnt + 5'd1;
        end
    end

    assign push = !start && (pad_push || word_push);
    assign pop  = !start && mem_req && mem_ack;

    t05_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Port outputs decode registered FIFO state only; wdata is gated so that
    // the unreset storage never shows through while idle.
    assign mem_req   = !fifo_empty;
    assign mem_sel   = mem_req ? 4'hF : 4'h0;
    assign mem_wdata = mem_req ? fifo_head : '0;
    assign busy      = (state != RUN) || (fifo_count != '0) || (bit_cnt != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            shreg        <= '0;
            bit_cnt      <= '0;
            bits_written <= '0;
            overflow     <= 1'b0;
            mem_addr     <= BASE_ADDR;
            flush_done   <= 1'b0;
        end else if (start) begin
            state        <= RUN;
            shreg        <= '0;
            bit_cnt      <= '0;
            bits_written <= '0;
            overflow     <= 1'b0;
            mem_addr     <= BASE_ADDR;
            flush_done   <= 1'b0;
        end else begin
            shreg      <= shreg_next;
            bit_cnt    <= bit_cnt_next;
            flush_done <= 1'b0;

            if (bit_valid) bits_written <= bits_written + 32'd1;
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (pop) mem_addr <= mem_addr + ADDR_STEP;

            case (state)
                RUN:     if (flush) state <= PAD;
                PAD:     state <= DRAIN;
                DRAIN: begin
                    if (fifo_empty) begin
                        flush_done <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_t05_bit_packer.sv
module tb_t05_bit_packer;

    localparam logic [31:0] BASE = 32'h1000_0040;

    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        flush = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] bits_written;
    logic        overflow;
    logic        busy;
    logic        flush_done;

    int checks = 0;
    int errors = 0;

    // Acknowledge driver controls (written by the main sequence only).
    logic ack_rand  = 1'b0;
    logic ack_level = 1'b0;
    int   ack_wait  = 0;

    // Write log (written by the monitor only).
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          req_total = 0;

    t05_bit_packer #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .flush        (flush),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_sel      (mem_sel),
        .bits_written (bits_written),
        .overflow     (overflow),
        .busy         (busy),
        .flush_done   (flush_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // SRAM side: records every accepted write.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            if (mem_req === 1'b1) req_total++;
            if (mem_req === 1'b1 && mem_ack === 1'b1) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
        end
    end

    // mem_ack driver: fixed level, or a random 0..5 cycle delay per write.
    always @(posedge clk) begin
        #1;
        if (ack_rand) begin
            if (mem_req === 1'b1 && ack_wait == 0) begin
                mem_ack  = 1'b1;
                ack_wait = $urandom_range(0, 5);
            end else begin
                mem_ack = 1'b0;
                if (mem_req === 1'b1 && ack_wait > 0) ack_wait--;
            end
        end else begin
            mem_ack = ack_level;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Pulses flush (optionally together with one bit) and counts cycles until
    // flush_done, where cycle 1 is the one right after the flush cycle.
    task automatic flush_wait(input bit with_bit, input bit b, input int budget, output int n);
        flush = 1'b1;
        if (with_bit) begin
            bit_valid = 1'b1;
            bit_in    = b;
        end
        tick();
        flush     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        n = 1;
        while (flush_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("flush_done_seen", {31'd0, flush_done}, 32'd1);
        tick();
        check("flush_done_one_cycle", {31'd0, flush_done}, 32'd0);
    endtask

    // Reference packing: bit i of the stream lands in word i/32 at weight
    // 2^(31 - i%32); a trailing partial word is zero padded.
    function automatic wq_t pack_bits(input bit b[$]);
        wq_t         w;
        logic [31:0] word;
        int          nwords;
        nwords = (b.size() + 31) / 32;
        for (int k = 0; k < nwords; k++) begin
            word = 32'd0;
            for (int j = 0; j < 32; j++) begin
                if (32 * k + j < b.size() && b[32 * k + j]) word = word + (32'h8000_0000 >> j);
            end
            w.push_back(word);
        end
        return w;
    endfunction

    task automatic check_writes(input string tag, input int first, input wq_t exp);
        check({tag, "_write_count"}, 32'(wr_data_q.size() - first), 32'(exp.size()));
        for (int i = 0; i < exp.size() && first + i < wr_data_q.size(); i++) begin
            check({tag, "_data"}, wr_data_q[first + i], exp[i]);
            check({tag, "_addr"}, wr_addr_q[first + i], BASE + 32'(4 * i));
        end
    endtask

    initial begin
        bit          stream[$];
        wq_t         exp_words;
        int          first;
        int          req_snap;
        int          n;
        logic [31:0] r;

        // ---- reset state ----
        ticks(2);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_sel", {28'd0, mem_sel}, 32'd0);
        check("rst_bits_written", bits_written, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
        rst = 1'b0;
        ack_level = 1'b1;
        ticks(2);

        // ---- 32 ones, ack tied high: one write, one request cycle ----
        pulse_start();
        first    = wr_data_q.size();
        req_snap = req_total;
        for (int i = 0; i < 32; i++) send_bit(1'b1);
        check("ones_req_next_cycle", {31'd0, mem_req}, 32'd1);
        check("ones_sel", {28'd0, mem_sel}, 32'h0000_000F);
        check("ones_wdata", mem_wdata, 32'hFFFF_FFFF);
        check("ones_bits_written", bits_written, 32'd32);
        ticks(4);
        stream.delete();
        for (int i = 0; i < 32; i++) stream.push_back(1'b1);
        check_writes("ones", first, pack_bits(stream));
        check("ones_req_cycles", 32'(req_total - req_snap), 32'd1);
        check("ones_idle_busy", {31'd0, busy}, 32'd0);

        // ---- short partial word then flush ----
        pulse_start();
        first = wr_data_q.size();
        stream = '{1, 0, 1, 0, 0, 0, 0, 0, 1};
        foreach (stream[i]) send_bit(stream[i]);
        check("partial_busy", {31'd0, busy}, 32'd1);
        flush_wait(1'b0, 1'b0, 40, n);
        check("partial_flush_latency", 32'(n), 32'd4);
        check("partial_busy_after", {31'd0, busy}, 32'd0);
        exp_words.delete();
        exp_words.push_back(32'hA080_0000);
        check_writes("partial", first, exp_words);

        // ---- ack held low, 160 bits: FIFO fills, fifth word dropped ----
        ack_level = 1'b0;
        ticks(2);
        pulse_start();
        first = wr_data_q.size();
        stream.delete();
        for (int i = 0; i < 160; i++) begin
            stream.push_back(1'($urandom_range(0, 1)));
            send_bit(stream[i]);
            if (i == 127) check("ovf_full_no_drop", {31'd0, overflow}, 32'd0);
        end
        exp_words = pack_bits(stream);
        check("ovf_overflow", {31'd0, overflow}, 32'd1);
        check("ovf_bits_written", bits_written, 32'd160);
        check("ovf_req_held", {31'd0, mem_req}, 32'd1);
        check("ovf_head_stable", mem_wdata, exp_words[0]);
        check("ovf_addr_stable", mem_addr, BASE);
        check("ovf_no_writes", 32'(wr_data_q.size() - first), 32'd0);
        ack_level = 1'b1;
        ticks(10);
        exp_words = exp_words[0:3];
        check_writes("ovf", first, exp_words);
        check("ovf_req_drained", {31'd0, mem_req}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // ---- flush in the same cycle as a word-completing bit ----
        pulse_start();
        check("start_clears_overflow", {31'd0, overflow}, 32'd0);
        first = wr_data_q.size();
        stream.delete();
        for (int i = 0; i < 31; i++) begin
            stream.push_back(1'($urandom_range(0, 1)));
            send_bit(stream[i]);
        end
        stream.push_back(1'b1);
        flush_wait(1'b1, 1'b1, 40, n);
        check("flushbit_latency", 32'(n), 32'd3);
        check_writes("flushbit", first, pack_bits(stream));
        check("flushbit_busy", {31'd0, busy}, 32'd0);

        // ---- flush with nothing pending ----
        first = wr_data_q.size();
        flush_wait(1'b0, 1'b0, 40, n);
        check("emptyflush_latency", 32'(n), 32'd3);
        check("emptyflush_no_write", 32'(wr_data_q.size() - first), 32'd0);

        // ---- random bits, random ack delay, flush ----
        ack_rand = 1'b1;
        ticks(2);
        pulse_start();
        first = wr_data_q.size();
        stream.delete();
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            stream.push_back(1'($urandom_range(0, 1)));
            send_bit(stream[i]);
        end
        check("rand_bits_written", bits_written, 32'd1000);
        flush_wait(1'b0, 1'b0, 300, n);
        check_writes("rand", first, pack_bits(stream));
        check("rand_no_overflow", {31'd0, overflow}, 32'd0);
        ack_rand  = 1'b0;
        ack_level = 1'b0;
        ticks(2);

        // ---- asynchronous reset while a write is pending ----
        pulse_start();
        for (int i = 0; i < 32; i++) send_bit(1'($urandom_range(0, 1)));
        check("prerst_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check("arst_mem_addr", mem_addr, BASE);
        check("arst_mem_sel", {28'd0, mem_sel}, 32'd0);
        check("arst_mem_wdata", mem_wdata, 32'd0);
        check("arst_bits_written", bits_written, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        #1;
        rst = 1'b0;
        ack_level = 1'b1;
        ticks(2);
        pulse_start();
        first = wr_data_q.size();
        stream.delete();
        for (int i = 0; i < 32; i++) begin
            r = $urandom;
            stream.push_back(r[5]);
            send_bit(stream[i]);
        end
        ticks(4);
        check_writes("postrst", first, pack_bits(stream));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
